// File: rtl/line_memory_pkg.sv
// line_memory_pkg: shared state encoding and width helper for the line memory
package line_memory_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  // Latency counter width: enough bits to hold DELAY-1 with headroom.
  function automatic int cnt_w(int delay);
    return $clog2(delay) + 1;
  endfunction
endpackage

// File: rtl/line_mem_array.sv
// line_mem_array: synchronous-write, combinational-read line storage with reset clear
module line_mem_array #(
  parameter int NUM_BLOCKS = 256,
  parameter int W = 128,
  localparam int IW = $clog2(NUM_BLOCKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [NUM_BLOCKS];
  // Clear every line on reset, otherwise write one line when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end
  assign rdata = mem_q[idx];
endmodule

// File: rtl/line_memory.sv
// line_memory: single-outstanding line read/write responder with fixed access latency
module line_memory
  import line_memory_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 256,
  parameter int DELAY = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);
  localparam int W = BLOCK_SIZE * 8;
  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int CW = cnt_w(DELAY);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q;
  logic [IW-1:0] idx_q, sel_idx;
  logic [W-1:0] din_q, sel_din, dout_q, rdata;
  logic valid_q, accept, go_done, sel_wr;
  logic unused_addr;
  integer num_reads, num_writes;
  assign unused_addr = ^addr[31:IW];
  assign mem_ready = state_q != BUSY;
  assign accept = is_input_valid && mem_ready && (mem_read ^ mem_write);
  // With DELAY==1 an accept completes at the very next edge, so the live
  // inputs feed the array; otherwise the captured request does.
  assign go_done = (accept && DELAY == 1) || (state_q == BUSY && cnt_q == CW'(1));
  assign sel_wr = accept ? mem_write : wr_q;
  assign sel_idx = accept ? addr[IW-1:0] : idx_q;
  assign sel_din = accept ? din : din_q;
  assign is_output_valid = valid_q;
  assign dout = dout_q;
  // Next state and latency countdown.
  always_comb begin
    state_d = accept ? (DELAY == 1 ? DONE : BUSY) : state_q == BUSY ? (cnt_q == CW'(1) ? DONE : BUSY) : IDLE;
    cnt_d = accept ? CW'(DELAY - 1) : state_q == BUSY ? cnt_q - CW'(1) : cnt_q;
  end
  // State, request capture and registered read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      din_q <= '0;
      valid_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        wr_q <= mem_write;
        idx_q <= addr[IW-1:0];
        din_q <= din;
      end
      valid_q <= go_done && !sel_wr;
      dout_q <= go_done && !sel_wr ? rdata : '0;
    end
  end
  // Accepted-request statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_reads <= 0;
      num_writes <= 0;
    end else if (accept) begin
      num_reads <= num_reads + (mem_read ? 1 : 0);
      num_writes <= num_writes + (mem_write ? 1 : 0);
    end
  end
  line_mem_array #(.NUM_BLOCKS(NUM_BLOCKS), .W(W)) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (go_done && sel_wr),
    .idx  (sel_idx),
    .wdata(sel_din),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: randomized scoreboard bench for line_memory at DELAY=4 and DELAY=1
module tb_line_memory;
  logic clk = 1'b0;
  logic rst[2], iv[2], rd[2], wr[2], ov[2], rdy[2];
  logic [31:0] ad[2];
  logic [127:0] di[2], dq[2];
  int checks = 0, fails = 0;
  int rem[2], nr[2], nw[2];
  bit pend[2], prd[2], armed[2];
  bit er, ev;
  logic [3:0] ix;
  logic [127:0] mdl[2][16];
  logic [127:0] expq[2][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    line_memory #(.BLOCK_SIZE(16), .NUM_BLOCKS(16), .DELAY(g == 0 ? 4 : 1)) u (
      .clk(clk), .reset(rst[g]), .is_input_valid(iv[g]), .addr(ad[g]),
      .mem_read(rd[g]), .mem_write(wr[g]), .din(di[g]),
      .is_output_valid(ov[g]), .dout(dq[g]), .mem_ready(rdy[g]));
  end

  function automatic int dl(int d);
    return d == 0 ? 4 : 1;
  endfunction

  function automatic void chk(string nm, int d, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s dut%0d got %h expected %h", nm, d, a, e);
    end
  endfunction

  // Monitor: timing model per DUT, data expectations from the scoreboard queues.
  always @(negedge clk) begin
    if (armed[0]) begin
      chk("num_reads", 0, 128'(g_dut[0].u.num_reads), 128'(nr[0]));
      chk("num_writes", 0, 128'(g_dut[0].u.num_writes), 128'(nw[0]));
    end
    if (armed[1]) begin
      chk("num_reads", 1, 128'(g_dut[1].u.num_reads), 128'(nr[1]));
      chk("num_writes", 1, 128'(g_dut[1].u.num_writes), 128'(nw[1]));
    end
    for (int d = 0; d < 2; d++) begin
      if (armed[d]) begin
        if (rem[d] > 0) rem[d]--;
        er = rem[d] == 0;
        ev = pend[d] && er && prd[d];
        chk("mem_ready", d, 128'(rdy[d]), 128'(er));
        chk("out_valid", d, 128'(ov[d]), 128'(ev));
        if (ev) begin
          checks++;
          if (expq[d].size() == 0) begin
            fails++;
            $display("FAIL rdata dut%0d got %h expected none", d, dq[d]);
          end else if (dq[d] !== expq[d][0]) begin
            fails++;
            $display("FAIL rdata dut%0d got %h expected %h", d, dq[d], expq[d][0]);
            void'(expq[d].pop_front());
          end else void'(expq[d].pop_front());
        end else chk("dout_idle", d, dq[d], 128'h0);
        if (er) pend[d] = 1'b0;
      end
      if (rst[d]) begin
        armed[d] = 1'b1;
        pend[d] = 1'b0;
        rem[d] = 0;
        nr[d] = 0;
        nw[d] = 0;
        expq[d].delete();
        for (int i = 0; i < 16; i++) mdl[d][i] = '0;
      end else if (armed[d] && iv[d] && rem[d] == 0 && (rd[d] ^ wr[d])) begin
        pend[d] = 1'b1;
        rem[d] = dl(d);
        prd[d] = rd[d];
        ix = ad[d][3:0];
        if (rd[d]) begin
          expq[d].push_back(mdl[d][ix]);
          nr[d]++;
        end else begin
          mdl[d][ix] = di[d];
          nw[d]++;
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(int d, bit r, bit w, logic [31:0] a, logic [127:0] x);
    int n = 0;
    iv[d] = 1'b1; rd[d] = r; wr[d] = w; ad[d] = a; di[d] = x;
    if (r ^ w) begin
      @(negedge clk);
      while (!rdy[d] && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (n >= 50) begin
        $display("FAIL accept_timeout dut%0d got mem_ready=0 for %0d cycles expected 1", d, n);
        $fatal(1, "timeout");
      end
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic do_reset(int d, int n);
    rst[d] = 1'b1;
    idle(n);
    rst[d] = 1'b0;
  endtask

  task automatic rand_ops(int d, int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      req(d, op == 0 || op >= 6, op == 0 || (op >= 2 && op <= 5), 32'($urandom_range(0, 31)),
          {$urandom, $urandom, $urandom, $urandom});
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; di[d] = '0;
    end
    idle(3);
    rst[0] = 1'b0; rst[1] = 1'b0;
    idle(1);
    req(0, 1, 1, 32'd6, 128'h1234);
    req(0, 0, 0, 32'd6, 128'h5678);
    idle(2);
    req(0, 1, 0, 32'd6, '0);
    idle(6);
    req(0, 1, 0, 32'd3, '0);
    idle(6);
    req(0, 0, 1, 32'd5, 128'hDEAD0000000000000000000000000005);
    req(0, 1, 0, 32'd5, '0);
    idle(6);
    req(0, 1, 0, 32'd5, '0);
    ad[0] = 32'd7;
    di[0] = {$urandom, $urandom, $urandom, $urandom};
    idle(6);
    req(0, 0, 1, 32'd2, 128'hCAFE);
    idle(1);
    do_reset(0, 1);
    req(0, 1, 0, 32'd2, '0);
    idle(6);
    rand_ops(0, 60);
    idle(8);
    req(1, 0, 1, 32'd20, 128'hBEEF0000000000000000000000000014);
    req(1, 1, 0, 32'd4, '0);
    idle(3);
    rand_ops(1, 60);
    idle(2);
    do_reset(1, 1);
    req(1, 1, 0, 32'd4, '0);
    idle(8);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
